store_narrow_unit: RTL
======================

Name: store_narrow_unit

Overview:
- Store-side counterpart of the 16-to-32 sign extender. The extender widens narrow values on the way into the datapath; this block narrows 32-bit register data on the way out to data memory.
- Takes a store request (address, 32-bit data, size), replicates the byte or halfword into the correct lanes and generates byte enables. Issues one word-aligned write to data memory using a valid/ready handshake.
- Sits between the MEM-stage store path and the data-memory write port.

Parameters:
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data width; fixed at 32, four byte lanes.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  32  byte address of store.
- req_data  in  32  source register value; low bits used for byte/half.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- mem_valid  out  1  memory write request.
- mem_ready  in  1  memory accepts write.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables; bit i = byte lane i (addr offset i).
- done  out  1  one-cycle pulse: store fully written.
- err  out  1  one-cycle pulse: illegal size or misaligned store dropped.

Behaviour:
- Reset values (reset_n low at a clk edge): state=IDLE, req_ready=0 during reset then 1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, err=0.
- Reset is synchronous only; asserting reset_n mid-transaction abandons it at the next edge. No done or err is produced, and mem_valid is 0 after that edge.
- Little-endian: data byte j goes to address addr+j.
- States: IDLE, ISSUE, ISSUE2 (split builds only).
- IDLE: req_ready=1. An accept is req_valid && req_ready at edge N. On accept, the block latches the request and computes lanes.
  - Legal and aligned: go to ISSUE; mem_valid=1 from cycle N+1.
  - Illegal (size=11, or halfword with addr[0]=1, or word with addr[1:0]!=0 without the split feature): err=1 for cycle N+1 only, no memory access, stay in IDLE.
- ISSUE: mem_valid=1. mem_addr, mem_wdata and mem_be stay stable until mem_ready. req_ready=0.
  - On mem_valid && mem_ready at edge M: done=1 in cycle M+1, mem_valid=0, return to IDLE.
  - req_ready=1 again in cycle M+1.
  - Minimum is 2 cycles per store when mem_ready is held high.
- Lane rules (off=addr[1:0]):
  - Byte: wdata={4{data[7:0]}}, be=4'b0001<<off.
  - Halfword: wdata={2{data[15:0]}}, be=4'b0011 (off=0) or 4'b1100 (off=2).
  - Word: wdata=data, be=4'b1111.
- mem_addr={addr[31:2],2'b00}.
- done and err are never both high. Neither is asserted while the block is in reset.
- Requests presented while req_ready=0 are ignored; the requester holds them.

Optional Feature:
- Macro MISALIGN_SPLIT_EN.
- Defined: misaligned halfword (off=1,3) and misaligned word (off!=0) are legal. They issue two beats: ISSUE, then ISSUE2.
  - Beat 1: word addr {addr[31:2],00}, lanes off..min(off+n-1,3), carrying data bytes 0..k-1.
  - Beat 2: word addr +4 (wraps 0xFFFFFFFC to 0x00000000), lanes 0.., carrying the remaining bytes.
  - Halfword at off=1 stays in one beat (be=0110). Only off=3 splits.
  - done pulses once, after the beat-2 handshake. Beat 2 mem_valid is asserted in the cycle after the beat-1 handshake.
- Undefined: ISSUE2 is absent, and misaligned halfword or word raises err as above.

Test Plan:
- Byte store: addr=0x00001003, data=0x123456AB, size=00 -> mem_addr=0x00001000, wdata=0xABABABAB, be=1000; done one cycle after mem_ready.
- Halfword store: addr=0x00000202, data=0xFFFF8001, size=01, mem_ready delayed 3 cycles -> outputs stable throughout at wdata=0x80018001, be=1100; single done pulse.
- Word store: addr=0x10, data=0xDEADBEEF, mem_ready held 1 -> be=1111; back-to-back requests accepted every 2 cycles.
- Illegal cases: size=11 -> err=1 at N+1 only, mem_valid never high. Word at addr=0x2 without MISALIGN_SPLIT_EN -> err.
- MISALIGN_SPLIT_EN: word addr=0xFFFFFFFE, data=0x11223344 -> beat 1 addr=0xFFFFFFFC be=1100 wdata[31:16]=0x3344; beat 2 addr=0x00000000 be=0011 wdata[15:0]=0x1122; one done.
- Reset mid-ISSUE (reset_n=0 while mem_ready=0) -> mem_valid=0 after the edge, no done, IDLE with req_ready=1 after release.

Source files
------------

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows 32-bit register data onto the data-memory write
//    port. It replicates the byte or halfword into the addressed lanes and builds
//    the byte enables.
// Latency: the request is accepted at edge N and mem_valid rises in cycle N+1.
//    done pulses in the cycle after the final write handshake, so an aligned
//    store takes at least 2 cycles.
// Backpressure: req_ready drops while a write is outstanding. mem_addr,
//    mem_wdata and mem_be stay stable until mem_ready, and the requester holds
//    its request until the next accept.
// Optional feature: define MISALIGN_SPLIT_EN to accept misaligned halfword and
//    word stores. A store that crosses a word boundary is issued as two beats.
//
// Ports:
//    clk, reset_n         clock (rising edge), synchronous active-low reset
//    req_valid/req_ready  store request handshake
//    req_addr             byte address of the store
//    req_data             source register value (low bits used for byte/half)
//    req_size             00 byte, 01 halfword, 10 word, 11 illegal
//    mem_valid/mem_ready  data-memory write handshake
//    mem_addr             word-aligned write address
//    mem_wdata            lane-placed write data
//    mem_be               byte enables, bit i = lane i (address offset i)
//    done                 one-cycle pulse: store completely written
//    err                  one-cycle pulse: illegal or misaligned store dropped
module store_narrow_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [1:0]        req_size,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // One word-aligned memory write
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [3:0]        be;
   } beat_t;

`ifdef MISALIGN_SPLIT_EN
   typedef enum logic [1:0] {IDLE, ISSUE, ISSUE2} state_t;
`else
   typedef enum logic [1:0] {IDLE, ISSUE} state_t;
`endif

   state_t            state, state_next;
   beat_t             cur_q;      // beat currently presented to memory
   beat_t             beat1_c;
   logic              done_q, err_q;
   logic              done_d, err_d;
   logic              accept;

   logic [1:0]        off;
   logic [3:0]        nmask;      // enables for the store size at offset 0
   logic [DATA_W-1:0] rep_data;   // lane-replicated data for aligned stores
   logic              natural_al; // store is aligned to its own size
   logic              illegal;

   assign off = req_addr[1:0];

   always_comb begin
      nmask      = 4'b1111;
      rep_data   = req_data;
      natural_al = 1'b0;
      case (req_size)
         SZ_BYTE: begin
            nmask      = 4'b0001;
            rep_data   = {4{req_data[7:0]}};
            natural_al = 1'b1;
         end
         SZ_HALF: begin
            nmask      = 4'b0011;
            rep_data   = {2{req_data[15:0]}};
            natural_al = ~off[0];
         end
         SZ_WORD: begin
            natural_al = (off == 2'b00);
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_SPLIT_EN
   // Place the value across a two-word window. The low word is beat 1 and the
   // high word holds whatever spills into the next word (beat 2).
   logic [7:0]          mask_w;
   logic [2*DATA_W-1:0] data_w;
   logic                split_c, split_q;
   logic                next_beat;
   beat_t               beat2_c, beat2_q;

   assign mask_w  = {4'b0000, nmask} << off;
   assign data_w  = {{DATA_W{1'b0}}, req_data} << {off, 3'b000};
   assign split_c = |mask_w[7:4];
   assign illegal = (req_size == 2'b11);

   always_comb begin
      beat1_c       = '0;
      beat2_c       = '0;
      beat1_c.addr  = {req_addr[ADDR_W-1:2], 2'b00};
      // Replicated lanes when aligned. Misaligned data must land exactly at
      // the byte offset, so it is taken from the shifted window.
      beat1_c.wdata = natural_al ? rep_data : data_w[DATA_W-1:0];
      beat1_c.be    = mask_w[3:0];
      // Address wraps naturally from the top word to zero
      beat2_c.addr  = beat1_c.addr + ADDR_W'(4);
      beat2_c.wdata = data_w[2*DATA_W-1:DATA_W];
      beat2_c.be    = mask_w[7:4];
   end
`else
   // Without splitting, any store that is not aligned to its size is dropped
   assign illegal = (req_size == 2'b11) | ~natural_al;

   always_comb begin
      beat1_c       = '0;
      beat1_c.addr  = {req_addr[ADDR_W-1:2], 2'b00};
      beat1_c.wdata = rep_data;
      beat1_c.be    = nmask << off;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and handshake outputs. reset_n gates the outputs so that the
   // block neither offers nor accepts anything while it is held in reset.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      req_ready  = 1'b0;
      mem_valid  = 1'b0;
`ifdef MISALIGN_SPLIT_EN
      next_beat  = 1'b0;
`endif
      case (state)
         IDLE: begin
            req_ready = reset_n;
            if (req_valid) begin
               if (illegal) begin
                  err_d = 1'b1;
               end else begin
                  accept     = 1'b1;
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            mem_valid = reset_n;
            if (mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
               if (split_q) begin
                  next_beat  = 1'b1;
                  state_next = ISSUE2;
               end else begin
                  done_d     = 1'b1;
                  state_next = IDLE;
               end
`else
               done_d     = 1'b1;
               state_next = IDLE;
`endif
            end
         end
`ifdef MISALIGN_SPLIT_EN
         ISSUE2: begin
            mem_valid = reset_n;
            if (mem_ready) begin
               done_d     = 1'b1;
               state_next = IDLE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // Datapath and pulse registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
         beat2_q <= '0;
         split_q <= 1'b0;
`endif
      end else begin
         done_q <= done_d;
         err_q  <= err_d;
         if (accept) begin
            cur_q   <= beat1_c;
`ifdef MISALIGN_SPLIT_EN
            beat2_q <= beat2_c;
            split_q <= split_c;
`endif
         end
`ifdef MISALIGN_SPLIT_EN
         else if (next_beat) begin
            cur_q <= beat2_q;
         end
`endif
      end
   end

   assign mem_addr  = cur_q.addr;
   assign mem_wdata = cur_q.wdata;
   assign mem_be    = cur_q.be;
   assign done      = done_q & reset_n;
   assign err       = err_q & reset_n;

endmodule
